i2c_master_arbiter: RTL and testbench

- Shares one byte-level I2C master command port between NUM_REQ requesters, e.g. the switch-poll engine, the LED writer and the FND writer.
- Grants requesters in round-robin order and issues one complete single-byte transaction per grant: [START][addr+RW][DATA][STOP].
- Routes the master's read data and status back to the granted requester.
- Guards every transaction with a timeout and aborts the master when it fires.

---
 rtl/i2c_master_arbiter.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master command port.
// One single-byte transaction per grant, guarded by a timeout that aborts the master.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [7*NUM_REQ-1:0]       req_addr,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [8*NUM_REQ-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic [1:0]                 rsp_err,
    output logic                       m_cmd_valid,
    input  logic                       m_cmd_ready,
    output logic [6:0]                 m_cmd_addr,
    output logic                       m_cmd_rw,
    output logic [7:0]                 m_cmd_wdata,
    input  logic                       m_done,
    input  logic [7:0]                 m_rdata,
    input  logic                       m_nack,
    output logic                       m_abort,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [6:0]      lat_addr;
    logic            lat_rw;
    logic [7:0]      lat_wdata;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            timeout;
    logic            do_grant;
    logic            do_done;
    logic            do_abort;
    int              j;

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!sel_found && req_valid[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        do_grant    = 1'b0;
        do_done     = 1'b0;
        do_abort    = 1'b0;
        m_cmd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    do_grant = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout) begin
                    do_abort = 1'b1;
                    state_d  = RESPOND;
                end else begin
                    m_cmd_valid = 1'b1;
                    if (m_cmd_ready) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // A completion landing on the timeout cycle takes priority.
                if (m_done) begin
                    do_done = 1'b1;
                    state_d = RESPOND;
                end else if (timeout) begin
                    do_abort = 1'b1;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            if (do_grant) begin
                lat_addr  <= req_addr[7*sel_idx +: 7];
                lat_rw    <= req_rw[sel_idx];
                lat_wdata <= req_wdata[8*sel_idx +: 8];
                grant_idx <= sel_idx;
                cnt       <= '0;
            end else if (state_q == ISSUE || state_q == WAIT_DONE) begin
                cnt <= cnt + 1'b1;
            end
            if (do_done) begin
                rsp_rdata <= lat_rw ? m_rdata : 8'h00;
                rsp_err   <= m_nack ? 2'b01 : 2'b00;
            end else if (do_abort) begin
                rsp_rdata <= 8'h00;
                rsp_err   <= 2'b10;
            end
            if (state_q == RESPOND) begin
                rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign m_abort     = do_abort;
    assign busy        = (state_q != IDLE);
    assign m_cmd_addr  = lat_addr;
    assign m_cmd_rw    = lat_rw;
    assign m_cmd_wdata = lat_wdata;
    assign rsp_valid   = (state_q == RESPOND) ?
                         ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a short timeout.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_i2c_master_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [20:0] req_addr;
    logic [2:0]  req_rw;
    logic [23:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [6:0]  m_cmd_addr;
    logic        m_cmd_rw;
    logic [7:0]  m_cmd_wdata;
    logic        m_done;
    logic [7:0]  m_rdata;
    logic        m_nack;
    logic        m_abort;
    logic [1:0]  grant_idx;
    logic        busy;

    int errors = 0;
    int checks = 0;

    i2c_master_arbiter #(
        .NUM_REQ(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_rw(req_rw),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .m_cmd_valid(m_cmd_valid),
        .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr),
        .m_cmd_rw(m_cmd_rw),
        .m_cmd_wdata(m_cmd_wdata),
        .m_done(m_done),
        .m_rdata(m_rdata),
        .m_nack(m_nack),
        .m_abort(m_abort),
        .grant_idx(grant_idx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        settle();
        checks++;
        if ({rsp_valid, m_cmd_valid, m_abort, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {rsp_valid, m_cmd_valid, m_abort, busy});
        end
        checks++;
        if ({grant_idx, rsp_err, rsp_rdata, m_cmd_addr} !== 19'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {grant_idx, rsp_err, rsp_rdata, m_cmd_addr});
        end
        cyc();
        rst = 1'b0;
        cyc();
        settle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int         order [4] = '{0, 1, 2, 0};
        logic [2:0] exp;
        cyc();
        req_valid   = 3'b111;
        req_rw      = 3'b000;
        m_cmd_ready = 1'b1;
        m_done      = 1'b1;
        m_rdata     = 8'h11;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 16) req_valid = 3'b000;
            settle();
            exp = (k % 4 == 3) ? (3'b001 << order[k/4]) : 3'b000;
            checks++;
            if (rsp_valid !== exp) begin
                errors++;
                $display("FAIL rr_rsp_valid k=%0d: got %b want %b",
                         k, rsp_valid, exp);
            end
            if (k % 4 == 3) begin
                checks++;
                if (grant_idx !== 2'(order[k/4]) || rsp_err !== 2'b00 ||
                    rsp_rdata !== 8'h00) begin
                    errors++;
                    $display("FAIL rr_grant k=%0d: got g=%0d e=%b d=%h want g=%0d e=00 d=00",
                             k, grant_idx, rsp_err, rsp_rdata, order[k/4]);
                end
            end
        end
        m_cmd_ready = 1'b0;
        m_done      = 1'b0;
        m_rdata     = 8'h00;
    endtask

    task automatic test_single_read();
        cyc();
        req_valid          = 3'b001;
        req_addr[6:0]      = 7'h57;
        req_rw[0]          = 1'b1;
        settle();
        checks++;
        if (m_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency: cmd_valid got %b want 0", m_cmd_valid);
        end
        cyc();
        settle();
        checks++;
        if (m_cmd_valid !== 1'b1 || m_cmd_addr !== 7'h57 || m_cmd_rw !== 1'b1 ||
            grant_idx !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_cmd: got v=%b a=%h rw=%b g=%0d b=%b want v=1 a=57 rw=1 g=0 b=1",
                     m_cmd_valid, m_cmd_addr, m_cmd_rw, grant_idx, busy);
        end
        cyc();
        cyc();
        m_cmd_ready = 1'b1;
        settle();
        checks++;
        if (m_cmd_valid !== 1'b1 || m_cmd_addr !== 7'h57) begin
            errors++;
            $display("FAIL rd_cmd_hold: got v=%b a=%h want v=1 a=57",
                     m_cmd_valid, m_cmd_addr);
        end
        cyc();
        m_cmd_ready = 1'b0;
        settle();
        checks++;
        if (m_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_cmd_drop: got %b want 0", m_cmd_valid);
        end
        cyc();
        m_done  = 1'b1;
        m_rdata = 8'hA5;
        m_nack  = 1'b0;
        cyc();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 8'hA5 || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL rd_rsp: got v=%b d=%h e=%b want v=001 d=a5 e=00",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        cyc();
        req_valid = 3'b000;
        settle();
        checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0 || rsp_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_after: got v=%b b=%b d=%h want v=000 b=0 d=a5",
                     rsp_valid, busy, rsp_rdata);
        end
    endtask

    task automatic test_nack();
        cyc();
        req_valid        = 3'b010;
        req_addr[13:7]   = 7'h20;
        req_rw[1]        = 1'b0;
        req_wdata[15:8]  = 8'h3C;
        cyc();
        m_cmd_ready = 1'b1;
        settle();
        checks++;
        if (m_cmd_valid !== 1'b1 || m_cmd_addr !== 7'h20 || m_cmd_rw !== 1'b0 ||
            m_cmd_wdata !== 8'h3C || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL nack_cmd: got v=%b a=%h rw=%b w=%h g=%0d want v=1 a=20 rw=0 w=3c g=1",
                     m_cmd_valid, m_cmd_addr, m_cmd_rw, m_cmd_wdata, grant_idx);
        end
        cyc();
        m_cmd_ready = 1'b0;
        m_done      = 1'b1;
        m_nack      = 1'b1;
        m_rdata     = 8'hFF;
        cyc();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b010 || rsp_err !== 2'b01 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL nack_rsp: got v=%b e=%b d=%h want v=010 e=01 d=00",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        cyc();
        req_valid = 3'b000;
    endtask

    task automatic test_timeout();
        cyc();
        req_valid     = 3'b001;
        req_addr[6:0] = 7'h11;
        req_rw[0]     = 1'b1;
        m_rdata       = 8'h77;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1) m_cmd_ready = 1'b1;
            if (k == 2) m_cmd_ready = 1'b0;
            settle();
            checks++;
            if (m_abort !== (k == 16)) begin
                errors++;
                $display("FAIL to_abort k=%0d: got %b want %b", k, m_abort, k == 16);
            end
        end
        cyc();
        settle();
        checks++;
        if (rsp_valid !== 3'b001 || rsp_err !== 2'b10 || rsp_rdata !== 8'h00 ||
            m_abort !== 1'b0) begin
            errors++;
            $display("FAIL to_rsp: got v=%b e=%b d=%h ab=%b want v=001 e=10 d=00 ab=0",
                     rsp_valid, rsp_err, rsp_rdata, m_abort);
        end
        cyc();
        req_valid = 3'b000;
        m_rdata   = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_after: got v=%b b=%b want v=000 b=0", rsp_valid, busy);
        end
    endtask

    task automatic test_after_timeout();
        cyc();
        req_valid        = 3'b100;
        req_addr[20:14]  = 7'h30;
        req_rw[2]        = 1'b1;
        cyc();
        m_cmd_ready = 1'b1;
        settle();
        checks++;
        if (grant_idx !== 2'd2 || m_cmd_addr !== 7'h30 || m_cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL next_cmd: got g=%0d a=%h v=%b want g=2 a=30 v=1",
                     grant_idx, m_cmd_addr, m_cmd_valid);
        end
        cyc();
        m_cmd_ready = 1'b0;
        m_done      = 1'b1;
        m_rdata     = 8'h5A;
        cyc();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b100 || rsp_rdata !== 8'h5A || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL next_rsp: got v=%b d=%h e=%b want v=100 d=5a e=00",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        cyc();
        req_valid = 3'b000;
    endtask

    task automatic test_simultaneous();
        cyc();
        req_valid     = 3'b001;
        req_addr[6:0] = 7'h12;
        req_rw[0]     = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1) m_cmd_ready = 1'b1;
            if (k == 2) m_cmd_ready = 1'b0;
            if (k == 16) begin
                m_done  = 1'b1;
                m_rdata = 8'hC3;
            end
        end
        settle();
        checks++;
        if (m_abort !== 1'b0) begin
            errors++;
            $display("FAIL sim_abort: got %b want 0", m_abort);
        end
        cyc();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b001 || rsp_err !== 2'b00 || rsp_rdata !== 8'hC3 ||
            m_abort !== 1'b0) begin
            errors++;
            $display("FAIL sim_rsp: got v=%b e=%b d=%h ab=%b want v=001 e=00 d=c3 ab=0",
                     rsp_valid, rsp_err, rsp_rdata, m_abort);
        end
        cyc();
        req_valid = 3'b000;
    endtask

    task automatic test_reset_mid();
        cyc();
        req_valid      = 3'b010;
        req_addr[13:7] = 7'h44;
        req_rw[1]      = 1'b0;
        cyc();
        m_cmd_ready = 1'b1;
        cyc();
        m_cmd_ready = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL rm_pre: got b=%b g=%0d want b=1 g=1", busy, grant_idx);
        end
        cyc();
        rst = 1'b1;
        settle();
        checks++;
        if ({busy, m_cmd_valid, m_abort, rsp_valid} !== 6'b0 ||
            {grant_idx, rsp_err, rsp_rdata, m_cmd_addr} !== 19'h0) begin
            errors++;
            $display("FAIL rm_async: got ctrl=%b data=%h want 0",
                     {busy, m_cmd_valid, m_abort, rsp_valid},
                     {grant_idx, rsp_err, rsp_rdata, m_cmd_addr});
        end
        cyc();
        rst       = 1'b0;
        req_valid = 3'b000;
        settle();
        checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_quiet: got v=%b b=%b want v=000 b=0", rsp_valid, busy);
        end
        cyc();
        req_valid       = 3'b100;
        req_addr[20:14] = 7'h55;
        req_rw[2]       = 1'b1;
        cyc();
        m_cmd_ready = 1'b1;
        settle();
        checks++;
        if (grant_idx !== 2'd2 || m_cmd_valid !== 1'b1 || m_cmd_addr !== 7'h55) begin
            errors++;
            $display("FAIL rm_regrant: got g=%0d v=%b a=%h want g=2 v=1 a=55",
                     grant_idx, m_cmd_valid, m_cmd_addr);
        end
        cyc();
        m_cmd_ready = 1'b0;
        m_done      = 1'b1;
        m_rdata     = 8'h99;
        cyc();
        m_done  = 1'b0;
        m_rdata = 8'h00;
        settle();
        checks++;
        if (rsp_valid !== 3'b100 || rsp_rdata !== 8'h99 || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL rm_rsp: got v=%b d=%h e=%b want v=100 d=99 e=00",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        cyc();
        req_valid = 3'b000;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_rw      = '0;
        req_wdata   = '0;
        m_cmd_ready = 1'b0;
        m_done      = 1'b0;
        m_rdata     = '0;
        m_nack      = 1'b0;
        test_reset();
        test_round_robin();
        test_reset();
        test_single_read();
        test_nack();
        test_timeout();
        test_after_timeout();
        test_simultaneous();
        test_reset_mid();
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
